// File: rtl/npc_lsu_pkg.sv
// Shared definitions for the NPC load/store unit: access sizes, FSM states
// and the per-size byte-lane mask helper.
package npc_lsu_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_ACCESS = 2'd2,
        S_RESP   = 2'd3
    } lsu_state_t;

    function automatic logic [3:0] base_mask(input logic [1:0] size);
        case (size)
            SZ_B:    base_mask = 4'h1;
            SZ_H:    base_mask = 4'h3;
            SZ_W:    base_mask = 4'hF;
            default: base_mask = 4'h0;
        endcase
    endfunction

    // Size 3 is illegal; halves need even addresses, words need 4-byte alignment.
    function automatic logic is_bad_access(input logic [1:0] size, input logic [1:0] off);
        is_bad_access = (size == 2'd3) ||
                        (size == SZ_H && off[0]) ||
                        (size == SZ_W && off != 2'b00);
    endfunction

endpackage

// File: rtl/npc_lsu_align.sv
// Combinational byte-lane logic: store data/mask placement and load
// extraction with sign or zero extension.
module npc_lsu_align
    import npc_lsu_pkg::*;
(
    input  logic [1:0]  i_st_off,
    input  logic [1:0]  i_st_size,
    input  logic [31:0] i_st_wdata,
    output logic [31:0] o_st_wdata,
    output logic [3:0]  o_st_mask,
    input  logic [1:0]  i_ld_off,
    input  logic [1:0]  i_ld_size,
    input  logic        i_ld_unsigned,
    input  logic [31:0] i_ld_word,
    output logic [31:0] o_ld_data
);

    logic [31:0] w_ld_shifted;

    assign o_st_wdata   = i_st_wdata << {i_st_off, 3'b000};
    assign o_st_mask    = base_mask(i_st_size) << i_st_off;
    assign w_ld_shifted = i_ld_word >> {i_ld_off, 3'b000};

    always_comb begin
        o_ld_data = w_ld_shifted;
        case (i_ld_size)
            SZ_B: o_ld_data = i_ld_unsigned ? {24'b0, w_ld_shifted[7:0]}
                                            : {{24{w_ld_shifted[7]}}, w_ld_shifted[7:0]};
            SZ_H: o_ld_data = i_ld_unsigned ? {16'b0, w_ld_shifted[15:0]}
                                            : {{16{w_ld_shifted[15]}}, w_ld_shifted[15:0]};
            default: o_ld_data = w_ld_shifted;
        endcase
    end

endmodule

// File: rtl/npc_lsu.sv
// Load/store unit between EXU/WBU and PMEM. One request in flight; a request
// transfers on req_valid && req_ready, a response on resp_valid && resp_ready.
module npc_lsu #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LAT    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wen,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              mem_valid,
    output logic [ADDR_W-1:0] mem_raddr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_wen,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [7:0]        mem_wmask,
    output logic [1:0]        dbg_state
);
    import npc_lsu_pkg::*;

    localparam int CNT_W = 8;

    lsu_state_t        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_req_ready;
    logic              r_wen;
    logic [ADDR_W-1:0] r_addr;
    logic [1:0]        r_size;
    logic              r_unsigned;
    logic [DATA_W-1:0] r_st_wdata;
    logic [3:0]        r_st_mask;
    logic              r_resp_valid;
    logic [DATA_W-1:0] r_resp_rdata;
    logic              r_resp_err;
    logic              r_mem_valid;
    logic              r_mem_wen;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [7:0]        r_mem_wmask;

    logic [DATA_W-1:0] w_st_wdata;
    logic [3:0]        w_st_mask;
    logic [DATA_W-1:0] w_ld_data;
    logic              w_req_err;

    // Store lanes are computed from the live request and kept at accept time;
    // load extraction works on the latched request and the memory word.
    npc_lsu_align u_align (
        .i_st_off      (req_addr[1:0]),
        .i_st_size     (req_size),
        .i_st_wdata    (req_wdata),
        .o_st_wdata    (w_st_wdata),
        .o_st_mask     (w_st_mask),
        .i_ld_off      (r_addr[1:0]),
        .i_ld_size     (r_size),
        .i_ld_unsigned (r_unsigned),
        .i_ld_word     (mem_rdata),
        .o_ld_data     (w_ld_data)
    );

    assign w_req_err = is_bad_access(req_size, req_addr[1:0]);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_req_ready  <= 1'b1;
            r_wen        <= 1'b0;
            r_addr       <= '0;
            r_size       <= '0;
            r_unsigned   <= 1'b0;
            r_st_wdata   <= '0;
            r_st_mask    <= '0;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
            r_resp_err   <= 1'b0;
            r_mem_valid  <= 1'b0;
            r_mem_wen    <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_mem_wmask  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_wen       <= req_wen;
                        r_addr      <= req_addr;
                        r_size      <= req_size;
                        r_unsigned  <= req_unsigned;
                        r_st_wdata  <= w_st_wdata;
                        r_st_mask   <= w_st_mask;
                        r_req_ready <= 1'b0;
                        if (w_req_err) begin
                            r_state      <= S_RESP;
                            r_resp_valid <= 1'b1;
                            r_resp_err   <= 1'b1;
                            r_resp_rdata <= '0;
                        end else if (LAT > 0) begin
                            r_state <= S_WAIT;
                            r_cnt   <= CNT_W'(LAT > 0 ? LAT - 1 : 0);
                        end else begin
                            r_state     <= S_ACCESS;
                            r_mem_valid <= 1'b1;
                            r_mem_wen   <= req_wen;
                            r_mem_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
                            r_mem_wdata <= req_wen ? w_st_wdata : '0;
                            r_mem_wmask <= req_wen ? {4'b0, w_st_mask} : 8'h00;
                        end
                    end
                end
                S_WAIT: begin
                    if (r_cnt == '0) begin
                        r_state     <= S_ACCESS;
                        r_mem_valid <= 1'b1;
                        r_mem_wen   <= r_wen;
                        r_mem_addr  <= {r_addr[ADDR_W-1:2], 2'b00};
                        r_mem_wdata <= r_wen ? r_st_wdata : '0;
                        r_mem_wmask <= r_wen ? {4'b0, r_st_mask} : 8'h00;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                S_ACCESS: begin
                    // Single-cycle strobe; the load word is only valid during it.
                    r_state      <= S_RESP;
                    r_mem_valid  <= 1'b0;
                    r_mem_wen    <= 1'b0;
                    r_mem_addr   <= '0;
                    r_mem_wdata  <= '0;
                    r_mem_wmask  <= 8'h00;
                    r_resp_valid <= 1'b1;
                    r_resp_err   <= 1'b0;
                    r_resp_rdata <= r_wen ? '0 : w_ld_data;
                end
                S_RESP: begin
                    if (resp_ready) begin
                        r_state      <= S_IDLE;
                        r_resp_valid <= 1'b0;
                        r_resp_rdata <= '0;
                        r_resp_err   <= 1'b0;
                        r_req_ready  <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign req_ready  = r_req_ready;
    assign resp_valid = r_resp_valid;
    assign resp_rdata = r_resp_rdata;
    assign resp_err   = r_resp_err;
    assign mem_valid  = r_mem_valid;
    assign mem_raddr  = r_mem_addr;
    assign mem_waddr  = r_mem_addr;
    assign mem_wen    = r_mem_wen;
    assign mem_wdata  = r_mem_wdata;
    assign mem_wmask  = r_mem_wmask;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_npc_lsu.sv
// Directed and randomized checks of npc_lsu against a byte-addressed
// reference memory; a second instance with LAT=4 covers reset during WAIT.
module tb_npc_lsu;
    import npc_lsu_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, rst4;
    logic        req_valid, req4_valid, req_wen, req_unsigned, resp_ready;
    logic [31:0] req_addr, req_wdata;
    logic [1:0]  req_size;

    logic        req_ready, resp_valid, resp_err, mem_valid, mem_wen;
    logic [31:0] resp_rdata, mem_raddr, mem_rdata, mem_waddr, mem_wdata;
    logic [7:0]  mem_wmask;
    logic [1:0]  dbg_state;

    logic        req_ready4, resp_valid4, resp_err4, mem_valid4, mem_wen4;
    logic [31:0] resp_rdata4, mem_raddr4, mem_rdata4, mem_waddr4, mem_wdata4;
    logic [7:0]  mem_wmask4;
    logic [1:0]  dbg_state4;

    npc_lsu #(.ADDR_W(32), .DATA_W(32), .LAT(1)) u_dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_wen(req_wen), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_size(req_size), .req_unsigned(req_unsigned),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .mem_valid(mem_valid), .mem_raddr(mem_raddr),
        .mem_rdata(mem_rdata), .mem_wen(mem_wen), .mem_waddr(mem_waddr),
        .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .dbg_state(dbg_state)
    );

    npc_lsu #(.ADDR_W(32), .DATA_W(32), .LAT(4)) u_dut4 (
        .clk(clk), .rst(rst4), .req_valid(req4_valid), .req_ready(req_ready4),
        .req_wen(req_wen), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_size(req_size), .req_unsigned(req_unsigned),
        .resp_valid(resp_valid4), .resp_ready(resp_ready), .resp_rdata(resp_rdata4),
        .resp_err(resp_err4), .mem_valid(mem_valid4), .mem_raddr(mem_raddr4),
        .mem_rdata(mem_rdata4), .mem_wen(mem_wen4), .mem_waddr(mem_waddr4),
        .mem_wdata(mem_wdata4), .mem_wmask(mem_wmask4), .dbg_state(dbg_state4)
    );

    // Physical memory driven by the DUT; reference memory is kept by the bench.
    logic [31:0] pmem [64];
    logic [31:0] init_words [64];
    logic [7:0]  ref_mem [256];
    int          mem4_pulses = 0;

    assign mem_rdata  = mem_valid ? pmem[mem_raddr[7:2]] : 32'hBAD0BAD0;
    assign mem_rdata4 = 32'h5A5A5A5A;

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 64; i++) pmem[i] <= init_words[i];
        end else if (mem_valid && mem_wen) begin
            for (int b = 0; b < 4; b++)
                if (mem_wmask[b]) pmem[mem_waddr[7:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
    end

    always @(posedge clk) if (mem_valid4) mem4_pulses <= mem4_pulses + 1;

    int          total = 0;
    int          bad = 0;
    logic [31:0] got_rdata, got_waddr, got_raddr, got_wdata;
    logic [7:0]  got_wmask;
    logic        got_err, got_wen;
    int          got_lat, got_pulses;
    logic [1:0]  rnd_sz;
    logic [31:0] rnd_a;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        total++;
        assert (obs === want) else begin
            bad++;
            $error("FAIL %s obs=0x%08h exp=0x%08h", tag, obs, want);
        end
    endtask

    task automatic do_req(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [1:0] size, input logic uns, input int hold);
        logic        want_err;
        logic [31:0] want_rd, raw, want_wd;
        logic [7:0]  want_m, bi;
        int          nb, off, lat, pulses;
        off      = int'(addr[1:0]);
        want_err = (size == 2'd3) || (size == SZ_H && addr[0]) || (size == SZ_W && addr[1:0] != 0);
        nb       = (size == SZ_B) ? 1 : (size == SZ_H) ? 2 : 4;
        want_rd  = 0;
        want_wd  = 0;
        want_m   = 0;
        if (!want_err && !wen) begin
            raw = 0;
            for (int i = 0; i < nb; i++) begin
                bi  = addr[7:0] + 8'(i);
                raw = raw | (32'(ref_mem[bi]) << (8 * i));
            end
            if (uns || nb == 4) want_rd = raw;
            else if (nb == 1)   want_rd = raw[7]  ? (raw | 32'hFFFFFF00) : raw;
            else                want_rd = raw[15] ? (raw | 32'hFFFF0000) : raw;
        end
        if (!want_err && wen) begin
            want_m  = 8'(((1 << nb) - 1) << off);
            want_wd = wdata << (8 * off);
            for (int i = 0; i < nb; i++) begin
                bi = addr[7:0] + 8'(i);
                ref_mem[bi] = wdata[8*i +: 8];
            end
        end

        @(negedge clk);
        req_valid = 1'b1; req_wen = wen; req_addr = addr; req_wdata = wdata;
        req_size = size; req_unsigned = uns; resp_ready = 1'b0;
        chk("acc_ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0; pulses = 0;
        do begin
            @(negedge clk);
            lat++;
            if (mem_valid) begin
                pulses++;
                got_wen = mem_wen; got_waddr = mem_waddr; got_raddr = mem_raddr;
                got_wmask = mem_wmask; got_wdata = mem_wdata;
            end
        end while (!resp_valid && lat < 50);
        got_lat = lat; got_pulses = pulses; got_rdata = resp_rdata; got_err = resp_err;
        chk("latency", 32'(lat), want_err ? 32'd1 : 32'd3);
        chk("resp_err", 32'(resp_err), 32'(want_err));
        chk("resp_rdata", resp_rdata, want_rd);
        chk("mem_pulses", 32'(pulses), want_err ? 32'd0 : 32'd1);
        if (!want_err) begin
            chk("mem_waddr", got_waddr, {addr[31:2], 2'b00});
            chk("mem_raddr", got_raddr, {addr[31:2], 2'b00});
            chk("mem_wen", 32'(got_wen), 32'(wen));
            if (wen) begin
                chk("mem_wmask", 32'(got_wmask), 32'(want_m));
                chk("mem_wdata", got_wdata, want_wd);
            end
        end
        for (int h = 0; h < hold; h++) begin
            req_valid = 1'b1; req_wen = 1'b0; req_addr = 32'h80000000; req_size = SZ_W;
            @(negedge clk);
            chk("hold_valid", 32'(resp_valid), 32'd1);
            chk("hold_rdata", resp_rdata, want_rd);
            chk("hold_err", 32'(resp_err), 32'(want_err));
            chk("hold_ready", 32'(req_ready), 32'd0);
            chk("hold_memv", 32'(mem_valid), 32'd0);
        end
        req_valid = 1'b0; resp_ready = 1'b1;
        @(negedge clk);
        chk("post_valid", 32'(resp_valid), 32'd0);
        chk("post_ready", 32'(req_ready), 32'd1);
        chk("post_memv", 32'(mem_valid), 32'd0);
        resp_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; rst4 = 1'b1;
        req_valid = 1'b0; req4_valid = 1'b0; req_wen = 1'b0; req_unsigned = 1'b0;
        resp_ready = 1'b0; req_addr = 32'h0; req_wdata = 32'h0; req_size = SZ_W;
        for (int i = 0; i < 64; i++) init_words[i] = $urandom;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_words[i / 4][8*(i % 4) +: 8];
        repeat (3) @(posedge clk);
        #1 rst = 1'b0; rst4 = 1'b0;
        @(negedge clk);
        chk("rst_state", 32'(dbg_state), 32'(S_IDLE));
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_rvalid", 32'(resp_valid), 32'd0);
        chk("rst_rdata", resp_rdata, 32'd0);
        chk("rst_err", 32'(resp_err), 32'd0);
        chk("rst_memv", 32'(mem_valid), 32'd0);
        chk("rst_wen", 32'(mem_wen), 32'd0);
        chk("rst_waddr", mem_waddr, 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        chk("rst_wmask", 32'(mem_wmask), 32'd0);

        do_req(1'b1, 32'h80000004, 32'hDEADBEEF, SZ_W, 1'b0, 0);
        chk("sw_mask", 32'(got_wmask), 32'h0F);
        chk("sw_addr", got_waddr, 32'h80000004);
        do_req(1'b0, 32'h80000004, 32'h0, SZ_W, 1'b0, 0);
        chk("lw_val", got_rdata, 32'hDEADBEEF);
        chk("lw_lat", 32'(got_lat), 32'd3);
        do_req(1'b1, 32'h80000003, 32'h000000A5, SZ_B, 1'b0, 0);
        chk("sb_mask", 32'(got_wmask), 32'h08);
        chk("sb_wdata", got_wdata, 32'hA5000000);
        do_req(1'b0, 32'h80000003, 32'h0, SZ_B, 1'b0, 0);
        chk("lb_signed", got_rdata, 32'hFFFFFFA5);
        do_req(1'b0, 32'h80000003, 32'h0, SZ_B, 1'b1, 0);
        chk("lbu", got_rdata, 32'h000000A5);
        do_req(1'b1, 32'h80000000, 32'h80011234, SZ_W, 1'b0, 0);
        do_req(1'b0, 32'h80000002, 32'h0, SZ_H, 1'b0, 0);
        chk("lh_signed", got_rdata, 32'hFFFF8001);
        do_req(1'b0, 32'h80000002, 32'h0, SZ_H, 1'b1, 0);
        chk("lhu", got_rdata, 32'h00008001);
        do_req(1'b0, 32'h80000002, 32'h0, SZ_W, 1'b0, 0);
        chk("mis_err", 32'(got_err), 32'd1);
        chk("mis_pulses", 32'(got_pulses), 32'd0);
        do_req(1'b0, 32'h80000000, 32'h0, 2'd3, 1'b0, 0);
        chk("sz3_err", 32'(got_err), 32'd1);
        chk("sz3_rdata", got_rdata, 32'd0);
        do_req(1'b0, 32'h80000004, 32'h0, SZ_W, 1'b0, 5);
        chk("hold_val", got_rdata, 32'hDEADBEEF);

        for (int t = 0; t < 40; t++) begin
            rnd_sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            rnd_a  = 32'h80000000 | 32'($urandom_range(0, 255));
            if ($urandom_range(0, 3) != 0) begin
                if (rnd_sz == SZ_H) rnd_a[0] = 1'b0;
                if (rnd_sz == SZ_W) rnd_a[1:0] = 2'b00;
            end
            do_req(1'($urandom_range(0, 1)), rnd_a, $urandom, rnd_sz,
                   1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
        end

        // Reset while the LAT=4 instance sits in WAIT.
        @(negedge clk);
        req_wen = 1'b1; req_addr = 32'h80000010; req_wdata = 32'h12345678; req_size = SZ_W;
        req4_valid = 1'b1;
        @(posedge clk);
        #1 req4_valid = 1'b0;
        @(negedge clk);
        chk("w4_state", 32'(dbg_state4), 32'(S_WAIT));
        chk("w4_ready", 32'(req_ready4), 32'd0);
        rst4 = 1'b1;
        @(posedge clk);
        #1 rst4 = 1'b0;
        @(negedge clk);
        chk("r4_state", 32'(dbg_state4), 32'(S_IDLE));
        chk("r4_ready", 32'(req_ready4), 32'd1);
        chk("r4_rvalid", 32'(resp_valid4), 32'd0);
        chk("r4_rdata", resp_rdata4, 32'd0);
        chk("r4_err", 32'(resp_err4), 32'd0);
        chk("r4_memv", 32'(mem_valid4), 32'd0);
        chk("r4_wen", 32'(mem_wen4), 32'd0);
        chk("r4_raddr", mem_raddr4, 32'd0);
        chk("r4_waddr", mem_waddr4, 32'd0);
        chk("r4_wdata", mem_wdata4, 32'd0);
        chk("r4_wmask", 32'(mem_wmask4), 32'd0);
        repeat (10) @(negedge clk);
        chk("r4_no_pulse", 32'(mem4_pulses), 32'd0);
        chk("r4_idle", 32'(dbg_state4), 32'(S_IDLE));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
